// File: rtl/cam_storm_fx.sv
// Lightning-storm camera effect: frame-level strike FSM plus
// a two-stage pixel pipeline that draws bolts and flash glow.
module cam_storm_fx #(
  parameter int CW           = 4,
  parameter int NUM_BOLTS    = 2,
  parameter int FLASH_FRAMES = 2,
  parameter int BOOST_MAX    = 3,
  parameter int Y_LIMIT      = 220
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          v_sync,
  input  logic          de,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          trigger,
  input  logic          auto_en,
  input  logic [CW-1:0] cam_r,
  input  logic [CW-1:0] cam_g,
  input  logic [CW-1:0] cam_b,
  output logic [CW-1:0] out_r,
  output logic [CW-1:0] out_g,
  output logic [CW-1:0] out_b,
  output logic          out_valid,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, FLASH, DECAY} state_t;

  localparam logic [CW-1:0] ONES = '1;
  localparam logic [CW-1:0] BOLT_B = ONES - (ONES >> 2);

  state_t              state, state_n;
  logic [CW-1:0]       boost, boost_n;
  logic [7:0]          flash_cnt, flash_cnt_n;
  logic [5:0]          frame_cnt;
  logic                pending;
  logic                v_sync_d;
  logic [15:0]         lfsr, lfsr_nx;
  logic signed [10:0]  base [NUM_BOLTS];
  logic                tick, req, auto_req, strike;

  logic [9:0]          s1_x, s1_y;
  logic [CW-1:0]       s1_r, s1_g, s1_b;
  logic                s1_de;

  // Byte k of the LFSR rotated right by s bits.
  function automatic logic [7:0] rot_byte(input logic [15:0] v,
                                          input int s);
    logic [31:0] d;
    d = {v, v};
    return d[s +: 8];
  endfunction

  assign tick     = v_sync & ~v_sync_d;
  assign req      = pending | trigger;
  assign auto_req = auto_en & (frame_cnt == 6'd63);
  assign lfsr_nx  = {lfsr[14:0],
                     lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign busy     = (state != IDLE);

  // Next-state logic for the strike FSM; only acts on a frame tick.
  always_comb begin
    state_n     = state;
    boost_n     = boost;
    flash_cnt_n = flash_cnt;
    strike      = 1'b0;
    if (tick) begin
      case (state)
        IDLE: strike = req | auto_req;
        FLASH: begin
          if (req)                  strike = 1'b1;
          else if (flash_cnt == '0) state_n = DECAY;
          else                      flash_cnt_n = flash_cnt - 8'd1;
        end
        DECAY: begin
          if (req) begin
            strike = 1'b1;
          end else if (boost <= CW'(1)) begin
            boost_n = '0;
            state_n = IDLE;
          end else begin
            boost_n = boost - CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
      if (strike) begin
        state_n     = FLASH;
        boost_n     = CW'(BOOST_MAX);
        flash_cnt_n = 8'(FLASH_FRAMES - 1);
      end
    end
  end

  // Frame-level state registers, strike LFSR and bolt positions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      boost     <= '0;
      flash_cnt <= '0;
      frame_cnt <= '0;
      pending   <= 1'b0;
      v_sync_d  <= 1'b0;
      lfsr      <= 16'hACE1;
      for (int k = 0; k < NUM_BOLTS; k++) base[k] <= 11'sd64;
    end else begin
      v_sync_d  <= v_sync;
      state     <= state_n;
      boost     <= boost_n;
      flash_cnt <= flash_cnt_n;
      if (tick) begin
        frame_cnt <= frame_cnt + 6'd1;
        pending   <= 1'b0;
      end else if (trigger) begin
        pending <= 1'b1;
      end
      if (strike) begin
        lfsr <= lfsr_nx;
        for (int k = 0; k < NUM_BOLTS; k++)
          base[k] <= 11'sd64 +
                     $signed({2'b00, rot_byte(lfsr_nx, 4 * k), 1'b0});
      end
    end
  end

  // Pixel stage 1: register the incoming pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_x  <= '0;
      s1_y  <= '0;
      s1_r  <= '0;
      s1_g  <= '0;
      s1_b  <= '0;
      s1_de <= 1'b0;
    end else begin
      s1_x  <= x;
      s1_y  <= y;
      s1_r  <= cam_r;
      s1_g  <= cam_g;
      s1_b  <= cam_b;
      s1_de <= de;
    end
  end

  logic signed [10:0] zz;
  logic               hit;
  logic [CW-1:0]      nr, ng, nb;
  logic [CW:0]        sr, sg, sb;

  // Zigzag offset of the bolt for the current 8-row band.
  always_comb begin
    case (s1_y[5:3])
      3'd0:    zz = 11'sd0;
      3'd1:    zz = 11'sd8;
      3'd2:    zz = -11'sd5;
      3'd3:    zz = 11'sd12;
      3'd4:    zz = -11'sd3;
      3'd5:    zz = 11'sd15;
      3'd6:    zz = -11'sd8;
      default: zz = 11'sd5;
    endcase
  end

  // Bolt hit test against every bolt centre for this row.
  always_comb begin
    logic signed [10:0] off, ctr, dx, adx, wd;
    hit = 1'b0;
    off = '0;
    ctr = '0;
    dx  = '0;
    adx = '0;
    wd  = (s1_y < 10'd100) ? 11'sd2 : 11'sd1;
    for (int k = 0; k < NUM_BOLTS; k++) begin
      off = k[0] ? -zz : zz;
      ctr = base[k] + off;
      dx  = $signed({1'b0, s1_x}) - ctr;
      adx = (dx < 0) ? -dx : dx;
      if (adx <= wd) hit = 1'b1;
    end
    hit = hit & (state == FLASH) & (s1_y < 10'(Y_LIMIT));
  end

  // Output colour selection: bolt, boosted glow, or dim idle.
  always_comb begin
    sr = {1'b0, s1_r} + {1'b0, boost};
    sg = {1'b0, s1_g} + {1'b0, boost};
    sb = {1'b0, s1_b} + {1'b0, boost};
    nr = s1_r >> 1;
    ng = s1_g >> 1;
    nb = (s1_b >> 1) + (s1_b >> 2);
    if (hit) begin
      nr = ONES;
      ng = ONES;
      nb = BOLT_B;
    end else if (state != IDLE) begin
      nr = sr[CW] ? ONES : sr[CW-1:0];
      ng = sg[CW] ? ONES : sg[CW-1:0];
      nb = sb[CW] ? ONES : sb[CW-1:0];
    end
  end

  // Pixel stage 2: register the processed pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_r     <= nr;
      out_g     <= ng;
      out_b     <= nb;
      out_valid <= s1_de;
    end
  end

endmodule

// File: tb/tb_cam_storm_fx.sv
// Randomised bench for cam_storm_fx with a frame-level
// reference model of the strike behaviour and pixel colours.
module tb_cam_storm_fx;

  localparam int CW = 4;
  localparam int NB = 2;
  localparam int FF = 2;
  localparam int BM = 3;
  localparam int YL = 220;
  localparam int MX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, v_sync, de, trigger, auto_en;
  logic [9:0]    x, y;
  logic [CW-1:0] cam_r, cam_g, cam_b;
  logic [CW-1:0] out_r, out_g, out_b;
  logic          out_valid, busy;

  cam_storm_fx #(
    .CW(CW), .NUM_BOLTS(NB), .FLASH_FRAMES(FF),
    .BOOST_MAX(BM), .Y_LIMIT(YL)
  ) dut (
    .clk(clk), .reset(reset), .v_sync(v_sync), .de(de),
    .x(x), .y(y), .trigger(trigger), .auto_en(auto_en),
    .cam_r(cam_r), .cam_g(cam_g), .cam_b(cam_b),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference: 0 idle, 1 flash, 2 decay
  int m_st, m_boost, m_fc, m_fcnt, m_pend, m_vsd, m_lfsr;
  int m_base [NB];
  int p_x, p_y, p_r, p_g, p_b, p_de;
  int zzt [8] = '{0, 8, -5, 12, -3, 15, -8, 5};
  int e_r, e_g, e_b, e_v;
  int strikes = 0;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MX) ? MX : v;
  endfunction

  task automatic ref_pix(input int px, py, pr, pg, pb,
                         output int er, eg, eb);
    bit hit = 0;
    if (m_st == 1 && py < YL) begin
      for (int k = 0; k < NB; k++) begin
        int c, d;
        c = m_base[k] + ((k % 2) ? -zzt[(py / 8) % 8]
                                 : zzt[(py / 8) % 8]);
        d = px - c;
        if (d < 0) d = -d;
        if (d <= ((py < 100) ? 2 : 1)) hit = 1;
      end
    end
    if (hit) begin
      er = MX; eg = MX; eb = MX - MX / 4;
    end else if (m_st != 0) begin
      er = sat(pr + m_boost);
      eg = sat(pg + m_boost);
      eb = sat(pb + m_boost);
    end else begin
      er = pr / 2; eg = pg / 2; eb = pb / 2 + pb / 4;
    end
  endtask

  task automatic ref_reset();
    m_st = 0; m_boost = 0; m_fc = 0; m_fcnt = 0;
    m_pend = 0; m_vsd = 0; m_lfsr = 'hACE1;
    for (int k = 0; k < NB; k++) m_base[k] = 64;
  endtask

  task automatic ref_strike();
    int fb, rot;
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^
          (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
    for (int k = 0; k < NB; k++) begin
      rot = ((m_lfsr >> (4 * k)) | (m_lfsr << (16 - 4 * k))) & 'hFFFF;
      m_base[k] = 64 + 2 * (rot & 'hFF);
    end
    m_st = 1; m_boost = BM; m_fc = FF - 1;
    strikes++;
  endtask

  task automatic ref_frame();
    bit tk, rq, st;
    tk = v_sync && !m_vsd;
    rq = m_pend || trigger;
    if (tk) begin
      st = 0;
      if (m_st == 0) st = rq || (auto_en && m_fcnt == 63);
      else if (rq) st = 1;
      else if (m_st == 1) begin
        if (m_fc == 0) m_st = 2;
        else m_fc--;
      end else begin
        m_boost--;
        if (m_boost <= 0) begin
          m_boost = 0; m_st = 0;
        end
      end
      if (st) ref_strike();
      m_fcnt = (m_fcnt + 1) % 64;
      m_pend = 0;
    end else if (trigger) begin
      m_pend = 1;
    end
    m_vsd = v_sync;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) begin
      ref_reset();
      e_r = 0; e_g = 0; e_b = 0; e_v = 0;
      p_x = 0; p_y = 0; p_r = 0; p_g = 0; p_b = 0; p_de = 0;
    end else begin
      ref_pix(p_x, p_y, p_r, p_g, p_b, e_r, e_g, e_b);
      e_v = p_de;
      ref_frame();
      p_x = x; p_y = y; p_r = cam_r; p_g = cam_g;
      p_b = cam_b; p_de = de;
    end
    #1;
    check("out_r", out_r, e_r);
    check("out_g", out_g, e_g);
    check("out_b", out_b, e_b);
    check("out_valid", out_valid, e_v);
    check("busy", busy, m_st != 0);
  endtask

  bit rand_cam = 0;

  task automatic px(input int xx, input int yy, input bit dd,
                    input bit vs, input bit tr);
    x = 10'(xx); y = 10'(yy); de = dd;
    v_sync = vs; trigger = tr;
    if (rand_cam) begin
      cam_r = CW'($urandom); cam_g = CW'($urandom);
      cam_b = CW'($urandom);
    end
    cyc();
    trigger = 1'b0;
  endtask

  // ymode < 0: random rows; otherwise fixed row ymode.
  task automatic frame(input int n, input int ymode,
                       input int trig_pm);
    px($urandom_range(0, 700), $urandom_range(0, 300), 0, 1,
       $urandom_range(0, 999) < trig_pm);
    px(0, 0, 0, 1, 0);
    for (int i = 0; i < n; i++)
      px($urandom_range(30, 650),
         (ymode < 0) ? $urandom_range(0, 300) : ymode,
         $urandom_range(0, 3) != 0, 0,
         $urandom_range(0, 999) < trig_pm);
  endtask

  initial begin
    reset = 1; v_sync = 0; de = 0; trigger = 0; auto_en = 0;
    x = '0; y = '0; cam_r = '0; cam_g = '0; cam_b = '0;
    ref_reset();
    cyc(); cyc();
    check("rst_out_r", out_r, 0);
    check("rst_busy", busy, 0);
    reset = 0;

    // Idle dimming with flat grey camera
    cam_r = 4'hA; cam_g = 4'hA; cam_b = 4'hA;
    for (int f = 0; f < 3; f++) frame(30, -1, 0);
    px(100, 300, 1, 0, 0); px(100, 300, 1, 0, 0);
    px(100, 300, 1, 0, 0);
    check("idle_r", out_r, 5);
    check("idle_g", out_g, 5);
    check("idle_b", out_b, 7);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 1);

    // Single mid-frame trigger, saturated glow, decay to idle
    cam_r = 4'hE; cam_g = 4'hE; cam_b = 4'hE;
    frame(10, 300, 0);
    px(200, 300, 1, 0, 1);
    px(200, 300, 1, 0, 0);
    check("pend_busy", busy, 0);
    frame(20, 300, 0);
    check("flash_busy", busy, 1);
    check("flash_r", out_r, MX);
    check("flash_b", out_b, MX);
    for (int f = 0; f < 4; f++) frame(20, 300, 0);
    check("decay_busy", busy, 1);
    frame(20, 300, 0);
    check("idle_again", busy, 0);
    check("idle_r2", out_r, 7);

    // Bolt sweeps from the first LFSR step
    rand_cam = 1;
    frame(5, 300, 0);
    px(0, 300, 0, 0, 1);
    px($urandom_range(0, 700), 10, 0, 1, 0);
    for (int xx = 0; xx < 700; xx++) px(xx, 10, 1, 0, 0);
    for (int xx = 0; xx < 700; xx++) px(xx, 150, 1, 0, 0);
    for (int xx = 0; xx < 700; xx++) px(xx, 220, 1, 0, 0);
    for (int yy = 0; yy < 240; yy++)
      px($urandom_range(40, 650), yy, 1, 0, 0);

    // Random triggers, including restrikes during decay
    for (int f = 0; f < 40; f++) frame(40, -1, 15);

    // Periodic auto strikes
    begin
      int s0;
      auto_en = 1;
      s0 = strikes;
      for (int f = 0; f < 140; f++) frame(8, -1, 0);
      check("auto_strikes", strikes - s0 >= 2, 1);
      auto_en = 0;
    end
    for (int f = 0; f < 6; f++) frame(8, -1, 0);

    // Trigger coincident with tick, then reset during flash
    px(300, 50, 0, 1, 1);
    for (int i = 0; i < 5; i++) px(300, 50, 1, 0, 0);
    check("coinc_busy", busy, 1);
    reset = 1; trigger = 1;
    cyc();
    check("rst2_r", out_r, 0);
    check("rst2_valid", out_valid, 0);
    check("rst2_busy", busy, 0);
    reset = 0; trigger = 0;
    frame(10, -1, 0);
    frame(10, -1, 0);
    check("rst2_nopend", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule

// File: doc/cam_storm_fx.md
CAM_STORM_FX -- requirements
Module: cam_storm_fx

Interface
REQ-001 Parameters SHALL be: CW, default 4, bits per colour channel; NUM_BOLTS, default 2, bolt count (1..4); FLASH_FRAMES, default 2, full-flash frames per strike; BOOST_MAX, default 3, peak brightness add (< 2^CW); Y_LIMIT, default 220, lowest bolt row (exclusive).
REQ-002 clk  in  1  pixel clock; single clock domain.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 v_sync  in  1  frame sync; rising edge marks frame start.
REQ-005 de  in  1  pixel valid for x, y, cam_*.
REQ-006 x, y  in  10 each  pixel coordinates.
REQ-007 trigger  in  1  strike request; any-cycle pulse.
REQ-008 auto_en  in  1  enables periodic self-strikes.
REQ-009 cam_r, cam_g, cam_b  in  CW each  camera pixel.
REQ-010 out_r, out_g, out_b  out  CW each  processed pixel.
REQ-011 out_valid  out  1  de delayed to match out_*.
REQ-012 busy  out  1  high when FSM not in IDLE.

Function
REQ-013 Frame tick SHALL be v_sync high with registered v_sync_d low; all frame-level state SHALL change only on a tick.
REQ-014 trigger SHALL set a sticky pending flag in any cycle; pending SHALL clear on the tick that consumes it.
REQ-015 A 6-bit frame counter SHALL increment on every tick, wrapping 63->0; with auto_en=1 the tick on which it wraps SHALL act as a strike request.
REQ-016 FSM states SHALL be IDLE, FLASH, DECAY.
REQ-017 IDLE->FLASH on a tick with pending or auto request; boost <= BOOST_MAX, flash_cnt <= FLASH_FRAMES-1, LFSR advanced once.
REQ-018 FLASH: on each tick, if pending -> restrike (reload as REQ-017); else if flash_cnt=0 -> DECAY; else flash_cnt decrements.
REQ-019 DECAY: on each tick, if pending -> FLASH (restrike); else boost decrements by 1; when boost reaches 0 on that tick -> IDLE.
REQ-020 Strike LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advanced only on strikes.
REQ-021 Bolt k base x SHALL be 64 + 2*byte_k, byte_k = bits [7:0] of the LFSR rotated right by 4k, latched at strike.
REQ-022 Bolt centre SHALL be base + zigzag(y[5:3]); zigzag table {0,+8,-5,+12,-3,+15,-8,+5}, negated for odd k; signed 11-bit arithmetic.
REQ-023 Pixel in bolt k iff state=FLASH, y < Y_LIMIT, |x - centre| <= w, w=2 for y<100 else 1; compare in 11-bit signed, no wrap.
REQ-024 Pixel priority: any bolt -> r=g=all-ones, b=all-ones minus (all-ones>>2); else state!=IDLE -> each channel cam+boost saturated at all-ones (CW+1-bit sum); else IDLE -> r=cam_r>>1, g=cam_g>>1, b=(cam_b>>1)+(cam_b>>2).
REQ-025 Pixel path SHALL be 2 register stages: latency 2 clk from x/y/cam_*/de to out_*/out_valid; no combinational input-to-output path.
REQ-026 Frame state used by the pixel path SHALL be that registered at the preceding tick; no mid-frame change.
REQ-027 trigger asserted in the same cycle as a tick SHALL be consumed by that tick.
REQ-028 Outputs with de=0 SHALL still be computed; out_valid is the only qualifier.

Reset
REQ-029 On reset high at a clk edge: state=IDLE, boost=0, flash_cnt=0, frame counter=0, pending=0, v_sync_d=0, LFSR=16'hACE1, bolt bases=64, pipeline regs and all outputs 0, busy=0.
REQ-030 Reset mid-strike SHALL abort to IDLE; a trigger in the reset cycle SHALL be discarded.

Verification
REQ-031 Reset, auto_en=0, cam=all 4'hA, 3 frames -> out_r=out_g=5, out_b=7, busy=0, out_valid = de delayed 2.
REQ-032 One trigger pulse mid-frame, defaults, cam=4'hE -> next tick busy=1; 2 frames non-bolt out=F (saturated); 3 DECAY frames with boost 2,1,0→IDLE on the 3rd DECAY tick.
REQ-033 Strike from reset seed, x swept at y=10 -> bolts at LFSR-derived centres, width 5 pixels, output F,F,C; at y=150 width 3; none at y>=220.
REQ-034 trigger during DECAY -> next tick FLASH, boost=3, LFSR advanced, new bolt positions.
REQ-035 auto_en=1, no trigger -> strike on the tick where frame counter wraps 63->0, every 64 frames.
REQ-036 trigger and tick coincident, then reset asserted during FLASH -> strike taken that tick; after reset all outputs 0, IDLE, pending=0.
